// File: rtl/nand_pkg.sv
// Shared definitions for the NAND operation sequencer: slot types, opcodes,
// flash command bytes and the sequencer state encoding.
package nand_pkg;

    typedef enum logic [1:0] {
        TYPE_CMD     = 2'b00,
        TYPE_ADDR    = 2'b01,
        TYPE_DATA_WR = 2'b10,
        TYPE_DATA_RD = 2'b11
    } slot_type_e;

    typedef enum logic [1:0] {
        OP_READ_ID   = 2'b00,
        OP_READ_PAGE = 2'b01,
        OP_PROGRAM   = 2'b10,
        OP_ERASE     = 2'b11
    } nand_op_e;

    localparam logic [7:0] CMD_READ1   = 8'h00;
    localparam logic [7:0] CMD_READ2   = 8'h30;
    localparam logic [7:0] CMD_PROG1   = 8'h80;
    localparam logic [7:0] CMD_PROG2   = 8'h10;
    localparam logic [7:0] CMD_ERASE1  = 8'h60;
    localparam logic [7:0] CMD_ERASE2  = 8'hD0;
    localparam logic [7:0] CMD_STATUS  = 8'h70;
    localparam logic [7:0] CMD_READ_ID = 8'h90;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD1,
        ST_ADDR,
        ST_DATA_WR,
        ST_CMD2,
        ST_WAIT_WB,
        ST_WAIT_RB,
        ST_STAT_CMD,
        ST_STAT_RD,
        ST_DATA_RD,
        ST_FIN
    } state_e;

    function automatic logic [7:0] first_cmd(input nand_op_e op);
        case (op)
            OP_READ_ID:   return CMD_READ_ID;
            OP_READ_PAGE: return CMD_READ1;
            OP_PROGRAM:   return CMD_PROG1;
            default:      return CMD_ERASE1;
        endcase
    endfunction

    function automatic logic [7:0] confirm_cmd(input nand_op_e op);
        case (op)
            OP_READ_PAGE: return CMD_READ2;
            OP_PROGRAM:   return CMD_PROG2;
            default:      return CMD_ERASE2;
        endcase
    endfunction

endpackage

// File: rtl/nand_rb_waiter.sv
// Ready/busy timing helper: bounds the wait for RB to fall after a confirm
// command and the wait for RB to return high.
module nand_rb_waiter #(
    parameter int TWB     = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic wb_active,
    input  logic rb_active,
    input  logic rb,
    output logic wb_done,
    output logic rb_done,
    output logic rb_timeout
);

    localparam int MAXC = (TIMEOUT > TWB) ? TIMEOUT : TWB;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // One counter serves both phases; it restarts whenever a phase ends.
    always_comb begin
        wb_done    = wb_active && (!rb || (cnt_q >= CW'(TWB - 1)));
        rb_done    = rb_active && rb;
        rb_timeout = rb_active && !rb && (cnt_q >= CW'(TIMEOUT - 1));
        if (!(wb_active || rb_active) || wb_done || rb_done || rb_timeout) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nand_op_sequencer.sv
// Turns one host request into the ordered stream of typed bytes for the NAND
// bus controller, including RB waits, status readback and error reporting.
module nand_op_sequencer
    import nand_pkg::*;
#(
    parameter int LEN_W   = 13,
    parameter int ID_LEN  = 4,
    parameter int TWB     = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic             SYSCLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_OP,
    input  logic [15:0]      REQ_COL,
    input  logic [23:0]      REQ_ROW,
    input  logic [LEN_W-1:0] REQ_LEN,
    input  logic [7:0]       WR_DATA,
    input  logic             WR_VALID,
    output logic             WR_READY,
    output logic [1:0]       TYPE,
    output logic [7:0]       IOH,
    output logic             BYTE_VALID,
    input  logic             BYTE_ACK,
    input  logic [7:0]       IOT,
    input  logic             RB,
    output logic [7:0]       RD_DATA,
    output logic             RD_VALID,
    output logic             DONE,
    output logic             ERR
);

    state_e           state_q, state_d;
    nand_op_e         op_q, op_d;
    logic [15:0]      col_q, col_d;
    logic [23:0]      row_q, row_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [2:0]       addr_idx_q, addr_idx_d;
    logic             err_q, err_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic             xfer;
    logic             addr_last;
    logic [7:0]       addr_byte;
    logic             wb_done, rb_done, rb_timeout;

    nand_rb_waiter #(
        .TWB     (TWB),
        .TIMEOUT (TIMEOUT)
    ) u_rb_waiter (
        .clk        (SYSCLK),
        .rst        (RST),
        .wb_active  (state_q == ST_WAIT_WB),
        .rb_active  (state_q == ST_WAIT_RB),
        .rb         (RB),
        .wb_done    (wb_done),
        .rb_done    (rb_done),
        .rb_timeout (rb_timeout)
    );

    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_READ_ID;
            col_q      <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            addr_idx_q <= '0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            col_q      <= col_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            addr_idx_q <= addr_idx_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // READ_ID carries a single 00h address; ERASE starts at the row bytes.
    always_comb begin
        addr_last = (op_q == OP_READ_ID) || (addr_idx_q == 3'd4);
        case (addr_idx_q)
            3'd0:    addr_byte = col_q[7:0];
            3'd1:    addr_byte = col_q[15:8];
            3'd2:    addr_byte = row_q[7:0];
            3'd3:    addr_byte = row_q[15:8];
            default: addr_byte = row_q[23:16];
        endcase
        if (op_q == OP_READ_ID) begin
            addr_byte = 8'h00;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        col_d      = col_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        addr_idx_d = addr_idx_q;
        err_d      = err_q;
        rd_valid_d = (state_q == ST_DATA_RD) && xfer;
        rd_data_d  = rd_valid_d ? IOT : rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    state_d    = ST_CMD1;
                    op_d       = nand_op_e'(REQ_OP);
                    col_d      = REQ_COL;
                    row_d      = REQ_ROW;
                    cnt_d      = (nand_op_e'(REQ_OP) == OP_READ_ID) ? LEN_W'(ID_LEN) : REQ_LEN;
                    addr_idx_d = (nand_op_e'(REQ_OP) == OP_ERASE) ? 3'd2 : 3'd0;
                    err_d      = 1'b0;
                end
            end
            ST_CMD1: begin
                if (xfer) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (xfer) begin
                    if (addr_last) begin
                        case (op_q)
                            OP_READ_ID: state_d = ST_DATA_RD;
                            OP_PROGRAM: state_d = (cnt_q == '0) ? ST_CMD2 : ST_DATA_WR;
                            default:    state_d = ST_CMD2;
                        endcase
                    end else begin
                        addr_idx_d = addr_idx_q + 3'd1;
                    end
                end
            end
            ST_DATA_WR: begin
                if (xfer) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                    if (cnt_q < LEN_W'(2)) begin
                        state_d = ST_CMD2;
                    end
                end
            end
            ST_CMD2: begin
                if (xfer) begin
                    state_d = ST_WAIT_WB;
                end
            end
            ST_WAIT_WB: begin
                if (wb_done) begin
                    state_d = ST_WAIT_RB;
                end
            end
            ST_WAIT_RB: begin
                if (rb_timeout) begin
                    state_d = ST_FIN;
                    err_d   = 1'b1;
                end else if (rb_done) begin
                    if (op_q == OP_READ_PAGE) begin
                        state_d = (cnt_q == '0) ? ST_FIN : ST_DATA_RD;
                    end else begin
                        state_d = ST_STAT_CMD;
                    end
                end
            end
            ST_STAT_CMD: begin
                if (xfer) begin
                    state_d = ST_STAT_RD;
                end
            end
            ST_STAT_RD: begin
                if (xfer) begin
                    err_d   = IOT[0];
                    state_d = ST_FIN;
                end
            end
            ST_DATA_RD: begin
                if (xfer) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                    if (cnt_q < LEN_W'(2)) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Program payload passes straight through so the controller's ack is
    // the producer's ready in the same cycle.
    always_comb begin
        REQ_READY  = (state_q == ST_IDLE);
        TYPE       = TYPE_CMD;
        IOH        = 8'h00;
        BYTE_VALID = 1'b0;
        WR_READY   = 1'b0;
        case (state_q)
            ST_CMD1: begin
                BYTE_VALID = 1'b1;
                IOH        = first_cmd(op_q);
            end
            ST_ADDR: begin
                TYPE       = TYPE_ADDR;
                BYTE_VALID = 1'b1;
                IOH        = addr_byte;
            end
            ST_DATA_WR: begin
                TYPE       = TYPE_DATA_WR;
                IOH        = WR_DATA;
                BYTE_VALID = WR_VALID;
                WR_READY   = BYTE_ACK;
            end
            ST_CMD2: begin
                BYTE_VALID = 1'b1;
                IOH        = confirm_cmd(op_q);
            end
            ST_STAT_CMD: begin
                BYTE_VALID = 1'b1;
                IOH        = CMD_STATUS;
            end
            ST_STAT_RD, ST_DATA_RD: begin
                TYPE       = TYPE_DATA_RD;
                BYTE_VALID = 1'b1;
            end
            default: begin
                BYTE_VALID = 1'b0;
            end
        endcase
        xfer     = BYTE_VALID && BYTE_ACK;
        DONE     = (state_q == ST_FIN);
        ERR      = err_q;
        RD_DATA  = rd_data_q;
        RD_VALID = rd_valid_q;
    end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Directed bench for nand_op_sequencer: a controller/flash emulator acks the
// byte stream, and the recorded slots are compared with a per-op byte model.
module tb_nand_op_sequencer;
    import nand_pkg::*;

    localparam int LEN_W   = 13;
    localparam int ID_LEN  = 4;
    localparam int TWB     = 8;
    localparam int TIMEOUT = 200;
    localparam int BUDGET  = 2000;

    logic             sysclk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [15:0]      req_col;
    logic [23:0]      req_row;
    logic [LEN_W-1:0] req_len;
    logic [7:0]       wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [1:0]       type_o;
    logic [7:0]       ioh;
    logic             byte_valid;
    logic             byte_ack;
    logic [7:0]       iot;
    logic             rb;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             done;
    logic             err;

    always #5 sysclk = ~sysclk;

    nand_op_sequencer #(
        .LEN_W   (LEN_W),
        .ID_LEN  (ID_LEN),
        .TWB     (TWB),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .SYSCLK     (sysclk),
        .RST        (rst),
        .REQ_VALID  (req_valid),
        .REQ_READY  (req_ready),
        .REQ_OP     (req_op),
        .REQ_COL    (req_col),
        .REQ_ROW    (req_row),
        .REQ_LEN    (req_len),
        .WR_DATA    (wr_data),
        .WR_VALID   (wr_valid),
        .WR_READY   (wr_ready),
        .TYPE       (type_o),
        .IOH        (ioh),
        .BYTE_VALID (byte_valid),
        .BYTE_ACK   (byte_ack),
        .IOT        (iot),
        .RB         (rb),
        .RD_DATA    (rd_data),
        .RD_VALID   (rd_valid),
        .DONE       (done),
        .ERR        (err)
    );

    typedef struct packed {
        logic [1:0]       op;
        logic [15:0]      col;
        logic [23:0]      row;
        logic [LEN_W-1:0] len;
        int               rb_low;
        int               stall;
        int               wr_gap;
        logic [3:0][7:0]  iot;
        logic [1:0][7:0]  wr;
        logic             exp_err;
        logic             exp_timeout;
    } vec_t;

    typedef struct packed {
        logic [1:0] t;
        logic [7:0] d;
    } slot_t;

    int    checks = 0;
    int    errors = 0;
    vec_t  vecs[8];
    slot_t exp_q[$];
    slot_t got_q[$];
    logic [7:0] rd_got[$];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t make_vec(input logic [1:0] op, input logic [15:0] col, input logic [23:0] row,
                                      input logic [LEN_W-1:0] len, input int rb_low, input int stall,
                                      input int wr_gap, input logic [31:0] iotv, input logic [15:0] wrv,
                                      input logic exp_err, input logic exp_timeout);
        vec_t v;
        v.op = op; v.col = col; v.row = row; v.len = len;
        v.rb_low = rb_low; v.stall = stall; v.wr_gap = wr_gap;
        v.iot = iotv; v.wr = wrv;
        v.exp_err = exp_err; v.exp_timeout = exp_timeout;
        return v;
    endfunction

    // Reference byte stream per operation; DATA_RD slots carry no IOH.
    task automatic build_expected(input vec_t v);
        exp_q.delete();
        case (v.op)
            2'b00: begin
                exp_q.push_back({2'b00, 8'h90});
                exp_q.push_back({2'b01, 8'h00});
                for (int k = 0; k < ID_LEN; k++) exp_q.push_back({2'b11, 8'h00});
            end
            2'b01, 2'b10: begin
                exp_q.push_back({2'b00, (v.op == 2'b01) ? 8'h00 : 8'h80});
                exp_q.push_back({2'b01, v.col[7:0]});
                exp_q.push_back({2'b01, v.col[15:8]});
                exp_q.push_back({2'b01, v.row[7:0]});
                exp_q.push_back({2'b01, v.row[15:8]});
                exp_q.push_back({2'b01, v.row[23:16]});
                if (v.op == 2'b01) begin
                    exp_q.push_back({2'b00, 8'h30});
                    if (!v.exp_timeout)
                        for (int k = 0; k < int'(v.len); k++) exp_q.push_back({2'b11, 8'h00});
                end else begin
                    for (int k = 0; k < int'(v.len); k++) exp_q.push_back({2'b10, v.wr[k]});
                    exp_q.push_back({2'b00, 8'h10});
                    if (!v.exp_timeout) begin
                        exp_q.push_back({2'b00, 8'h70});
                        exp_q.push_back({2'b11, 8'h00});
                    end
                end
            end
            default: begin
                exp_q.push_back({2'b00, 8'h60});
                exp_q.push_back({2'b01, v.row[7:0]});
                exp_q.push_back({2'b01, v.row[15:8]});
                exp_q.push_back({2'b01, v.row[23:16]});
                exp_q.push_back({2'b00, 8'hD0});
                if (!v.exp_timeout) begin
                    exp_q.push_back({2'b00, 8'h70});
                    exp_q.push_back({2'b11, 8'h00});
                end
            end
        endcase
    endtask

    task automatic apply_stimulus(input vec_t v, input int vi);
        @(posedge sysclk); #1;
        check_output($sformatf("v%0d_req_ready_idle", vi), req_ready, 1);
        req_valid = 1'b1; req_op = v.op; req_col = v.col; req_row = v.row; req_len = v.len;
        @(posedge sysclk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_vector(input vec_t v, input int vi);
        int rb_left = 0, stall_cnt = 0, wr_idx = 0, wr_gap_left = v.wr_gap, rd_idx = 0;
        int done_cnt = 0, done_cycle = -1, last_ack = -1, cmd2_cycle = -1, first_rd = -1;
        int stab_err = 0, wrrdy_err = 0, wrrdy_seen = 0, rd_err = 0, cyc = 0, n;
        logic pend_rd = 1'b0, after_status = 1'b0, prev_hold = 1'b0, err_at_done = 1'b0, xfer;
        logic [7:0] pend_val = 8'h00, prev_d = 8'h00;
        logic [1:0] prev_t = 2'b00;
        int exp_rd, exp_wr;

        build_expected(v);
        got_q.delete();
        rd_got.delete();
        rb = 1'b1;
        byte_ack = 1'b0;
        apply_stimulus(v, vi);

        while (done_cnt == 0 && cyc < BUDGET) begin
            rb       = (rb_left == 0);
            wr_valid = (wr_gap_left == 0) && (wr_idx < int'(v.len));
            wr_data  = v.wr[wr_idx[0]];
            iot      = v.iot[rd_idx[1:0]];
            #1;
            if (cyc == 0) begin
                check_output($sformatf("v%0d_first_byte_valid", vi), byte_valid, 1);
                check_output($sformatf("v%0d_req_ready_busy", vi), req_ready, 0);
            end
            if (byte_valid) begin
                if (stall_cnt < v.stall) begin
                    byte_ack = 1'b0;
                    stall_cnt++;
                end else begin
                    byte_ack = 1'b1;
                    stall_cnt = 0;
                end
            end else begin
                byte_ack = 1'b0;
            end
            if (prev_hold && (!byte_valid || type_o !== prev_t || ioh !== prev_d)) stab_err++;

            @(negedge sysclk);
            if (wr_gap_left > 0) wr_gap_left--;
            if (rb_left > 0) rb_left--;
            if (wr_ready) begin
                wrrdy_seen++;
                if (!(type_o == 2'b10 && byte_valid && byte_ack)) wrrdy_err++;
            end
            if (rd_valid !== pend_rd || (pend_rd && rd_data !== pend_val)) rd_err++;
            if (rd_valid) rd_got.push_back(rd_data);
            pend_rd = 1'b0;
            if (done) begin
                done_cnt++;
                done_cycle  = cyc;
                err_at_done = err;
            end
            xfer = byte_valid && byte_ack;
            if (xfer) begin
                got_q.push_back({type_o, (type_o == 2'b11) ? 8'h00 : ioh});
                last_ack = cyc;
                if (type_o == 2'b11) begin
                    if (!after_status) begin
                        pend_rd  = 1'b1;
                        pend_val = iot;
                        if (first_rd < 0) first_rd = cyc;
                    end
                    rd_idx++;
                end
                if (type_o == 2'b00 && ioh == 8'h70) after_status = 1'b1;
                if (type_o == 2'b00 && (ioh == 8'h30 || ioh == 8'h10 || ioh == 8'hD0)) begin
                    rb_left    = v.rb_low;
                    cmd2_cycle = cyc;
                end
                if (type_o == 2'b10) begin
                    wr_idx++;
                    wr_gap_left = v.wr_gap;
                end
            end
            prev_hold = byte_valid && !byte_ack;
            prev_t    = type_o;
            prev_d    = ioh;
            @(posedge sysclk); #1;
            byte_ack = 1'b0;
            cyc++;
        end

        check_output($sformatf("v%0d_done_count", vi), done_cnt, 1);
        check_output($sformatf("v%0d_err_at_done", vi), err_at_done, v.exp_err);
        check_output($sformatf("v%0d_req_ready_after_done", vi), req_ready, 1);
        check_output($sformatf("v%0d_err_held", vi), err, v.exp_err);
        check_output($sformatf("v%0d_slot_count", vi), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_output($sformatf("v%0d_slot%0d", vi, i), got_q[i], exp_q[i]);

        exp_rd = (v.op == 2'b00) ? ID_LEN : ((v.op == 2'b01 && !v.exp_timeout) ? int'(v.len) : 0);
        check_output($sformatf("v%0d_rd_count", vi), rd_got.size(), exp_rd);
        for (int i = 0; i < rd_got.size() && i < exp_rd; i++)
            check_output($sformatf("v%0d_rd%0d", vi, i), rd_got[i], v.iot[i]);
        check_output($sformatf("v%0d_rd_timing_errs", vi), rd_err, 0);
        check_output($sformatf("v%0d_stable_errs", vi), stab_err, 0);
        check_output($sformatf("v%0d_wr_ready_errs", vi), wrrdy_err, 0);
        exp_wr = (v.op == 2'b10) ? int'(v.len) : 0;
        check_output($sformatf("v%0d_wr_ready_count", vi), wrrdy_seen, exp_wr);

        if (v.exp_timeout)
            check_output($sformatf("v%0d_timeout_delay_ok", vi),
                         (done_cycle - last_ack >= TIMEOUT) && (done_cycle - last_ack <= TIMEOUT + 3), 1);
        else
            check_output($sformatf("v%0d_done_delay", vi), done_cycle - last_ack, 1);

        if (v.op == 2'b01 && v.len != 0)
            check_output($sformatf("v%0d_rd_after_rb", vi),
                         (first_rd - cmd2_cycle) > ((v.rb_low > 0) ? v.rb_low : TWB), 1);
    endtask

    initial begin
        int dones;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_col = '0; req_row = '0; req_len = '0;
        wr_data = 8'h00; wr_valid = 1'b0; byte_ack = 1'b0; iot = 8'h00; rb = 1'b1;

        vecs[0] = make_vec(2'b00, 16'h0000, 24'h000000, 0, 0,      0, 0, 32'h9590DA2C, 16'h0000, 1'b0, 1'b0);
        vecs[1] = make_vec(2'b01, 16'h0012, 24'h034567, 3, 20,     0, 0, 32'h00332211, 16'h0000, 1'b0, 1'b0);
        vecs[2] = make_vec(2'b10, 16'h0100, 24'h000203, 2, 5,      3, 2, 32'h00000000, 16'h3CA5, 1'b0, 1'b0);
        vecs[3] = make_vec(2'b10, 16'h0204, 24'h0A0B0C, 1, 3,      0, 0, 32'h00000001, 16'h00A5, 1'b1, 1'b0);
        vecs[4] = make_vec(2'b11, 16'h0000, 24'h0ABCDE, 0, 100000, 0, 0, 32'h00000000, 16'h0000, 1'b1, 1'b1);
        vecs[5] = make_vec(2'b10, 16'h5566, 24'h778899, 0, 3,      0, 0, 32'h00000000, 16'h0000, 1'b0, 1'b0);
        vecs[6] = make_vec(2'b11, 16'h0000, 24'h123456, 0, 4,      1, 0, 32'h00000000, 16'h0000, 1'b0, 1'b0);
        vecs[7] = make_vec(2'b01, 16'hABCD, 24'h00FF01, 1, 0,      0, 0, 32'h0000005A, 16'h0000, 1'b0, 1'b0);

        #2;
        check_output("rst_req_ready", req_ready, 1);
        check_output("rst_byte_valid", byte_valid, 0);
        check_output("rst_type", type_o, 0);
        check_output("rst_ioh", ioh, 0);
        check_output("rst_wr_ready", wr_ready, 0);
        check_output("rst_rd_valid", rd_valid, 0);
        check_output("rst_rd_data", rd_data, 0);
        check_output("rst_done", done, 0);
        check_output("rst_err", err, 0);
        repeat (2) @(posedge sysclk);
        @(negedge sysclk) rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vector(vecs[i], i);

        // Abort a READ_PAGE in the middle of its address bytes.
        @(posedge sysclk); #1;
        req_valid = 1'b1; req_op = 2'b01; req_col = 16'h0012; req_row = 24'h034567; req_len = 3;
        @(posedge sysclk); #1;
        req_valid = 1'b0;
        byte_ack  = 1'b1;
        repeat (3) @(posedge sysclk);
        #1;
        check_output("abort_in_addr_type", type_o, 2'b01);
        check_output("abort_in_addr_ioh", ioh, 8'h67);
        byte_ack = 1'b0;
        @(negedge sysclk) rst = 1'b1;
        #1;
        check_output("abort_req_ready", req_ready, 1);
        check_output("abort_byte_valid", byte_valid, 0);
        check_output("abort_type", type_o, 0);
        check_output("abort_ioh", ioh, 0);
        check_output("abort_wr_ready", wr_ready, 0);
        check_output("abort_rd_valid", rd_valid, 0);
        check_output("abort_rd_data", rd_data, 0);
        check_output("abort_done", done, 0);
        check_output("abort_err", err, 0);
        repeat (2) @(posedge sysclk);
        @(negedge sysclk) rst = 1'b0;
        dones = 0;
        repeat (6) begin
            @(negedge sysclk);
            if (done) dones++;
        end
        check_output("abort_no_done", dones, 0);
        check_output("abort_idle_ready", req_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
